// File: rtl/dcache_controller_if.sv
// CPU-side and data-memory-side signals of the direct-mapped L1 data cache.
// The slave modport is the cache controller; master is the CPU pipeline plus data memory.
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  // Handshake: the CPU holds cpu_req_i and its fields stable while cpu_stall_o is high;
  // the access completes on the first clock edge with cpu_stall_o low. On the memory
  // side mem_enable_o/mem_write_o/mem_addr_o/mem_data_o stay constant until the
  // one-cycle mem_ack_i pulse; refill data arrives on mem_data_i the cycle after it.
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 256-bit lines.
// Misses write back a dirty victim, then refill the line from data memory.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_controller_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  localparam int TAG_W = 32 - INDEX_W - 5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [255:0]         r_data [NUM_LINES];

  logic         r_mem_enable, r_mem_write;
  logic [31:0]  r_mem_addr;
  logic [255:0] r_mem_data;
  logic         w_mem_enable, w_mem_write;
  logic [31:0]  w_mem_addr;
  logic [255:0] w_mem_data;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [255:0]       w_line, w_merged;
  logic               w_hit, w_write_hit, w_refill, w_unused;

  assign w_index  = bus.cpu_addr_i[INDEX_W+4:5];
  assign w_tag    = bus.cpu_addr_i[31:INDEX_W+5];
  assign w_word   = bus.cpu_addr_i[4:2];
  assign w_unused = &{1'b0, bus.cpu_addr_i[1:0]};
  assign w_line   = r_data[w_index];
  // Hits are only recognised in IDLE, so an in-flight miss always reports a stall.
  assign w_hit    = (r_state == S_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);

  always_comb begin
    w_merged = w_line;
    w_merged[{w_word, 5'b0} +: 32] = bus.cpu_data_i;
  end

  always_comb begin
    w_next       = r_state;
    w_mem_enable = r_mem_enable;
    w_mem_write  = r_mem_write;
    w_mem_addr   = r_mem_addr;
    w_mem_data   = r_mem_data;
    w_write_hit  = 1'b0;
    w_refill     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req_i) begin
          if (w_hit) begin
            w_write_hit = bus.cpu_write_i;
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next       = S_WRITEBACK;
            w_mem_enable = 1'b1;
            w_mem_write  = 1'b1;
            w_mem_addr   = {r_tag[w_index], w_index, 5'b0};
            w_mem_data   = w_line;
          end else begin
            w_next       = S_ALLOCATE;
            w_mem_enable = 1'b1;
            w_mem_write  = 1'b0;
            w_mem_addr   = {w_tag, w_index, 5'b0};
          end
        end
      end
      S_WRITEBACK: begin
        // Enable stays high: the refill request follows the writeback back-to-back.
        if (bus.mem_ack_i) begin
          w_next      = S_ALLOCATE;
          w_mem_write = 1'b0;
          w_mem_addr  = {w_tag, w_index, 5'b0};
        end
      end
      S_ALLOCATE: begin
        if (bus.mem_ack_i) begin
          w_next       = S_REFILL;
          w_mem_enable = 1'b0;
        end
      end
      S_REFILL: begin
        w_refill = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_state      <= w_next;
      r_mem_enable <= w_mem_enable;
      r_mem_write  <= w_mem_write;
      r_mem_addr   <= w_mem_addr;
      r_mem_data   <= w_mem_data;
      if (w_refill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end else if (w_write_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; validity alone decides whether they are used.
  always_ff @(posedge clk_i) begin
    if (w_refill) begin
      r_data[w_index] <= bus.mem_data_i;
      r_tag[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      r_data[w_index] <= w_merged;
    end
  end

  assign bus.cpu_stall_o  = bus.cpu_req_i && !w_hit;
  assign bus.cpu_data_o   = w_hit ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;
  assign dbg_state_o      = r_state;
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage and the 256-bit-line data memory.
- Serves 32-bit word loads and stores from internal tag and data arrays; stalls the CPU on a miss.
- On a miss, writes back the dirty victim line, then refills the line through the data memory's enable/write/ack handshake.

Parameters:
- NUM_LINES, 32, number of cache lines (power of two).
- INDEX_W, 5, log2(NUM_LINES); tag width = 32 - INDEX_W - 5.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_req_i  in  1  CPU access request; held stable until cpu_stall_o is low.
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; [4:2] word select, [4+INDEX_W:5] index, upper bits tag; [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  1 = access not complete this cycle.
- mem_enable_o  out  1  memory request (registered).
- mem_write_o  out  1  memory write qualifier, valid whenever mem_enable_o is high (registered).
- mem_addr_o  out  32  line address, bits [4:0] = 0 (registered).
- mem_data_o  out  256  writeback line data (registered).
- mem_data_i  in  256  refill data; valid the cycle after mem_ack_i.
- mem_ack_i  in  1  one-cycle transaction-complete pulse.

Behaviour:
- Reset (async, rst_i = 1):
  - state = IDLE.
  - All valid and dirty bits cleared.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - cpu_data_o = 0 when no hit; cpu_stall_o = 0 while cpu_req_i = 0.
  - Data and tag arrays are not reset.
  - Reset mid-miss abandons the transaction; no partial line is written into the cache.
- hit = valid[index] and (tag[index] == addr tag). Evaluated combinationally in IDLE.
- cpu_stall_o = cpu_req_i and (state != IDLE or not hit).
- Read hit: cpu_data_o = selected word of the line, same cycle, zero latency. cpu_data_o = 0 when not a hit in IDLE.
- Write hit: at the clock edge, write cpu_data_i into the selected word and set dirty[index] = 1. Other words in the line are unchanged.
- States:
  - IDLE. On req and not hit:
    - If the victim is valid and dirty: go to WRITEBACK. Set mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
    - Otherwise: go to ALLOCATE. Set mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - WRITEBACK. Hold all mem outputs until mem_ack_i. On the ack edge: go to ALLOCATE, keep mem_enable_o = 1, set mem_write_o = 0 and mem_addr_o = refill address. Enable stays high across this transition; the memory is idle again on the following cycle.
  - ALLOCATE. Hold outputs until mem_ack_i. On the ack edge: mem_enable_o = 0, go to REFILL.
  - REFILL. One cycle. Capture mem_data_i into the data array, write the tag, set valid = 1 and dirty = 0, go to IDLE. The held request then hits in IDLE; a held store completes as a write hit and sets dirty.
- mem_enable_o must be low on the cycle after the final ack, so the memory does not start a spurious transaction.
- With the team's 8-cycle data memory (ack is the 8th busy cycle, read data registered at ack):
  - Clean miss: cpu_stall_o high for 11 cycles, result on the 12th.
  - Dirty miss: stall high for 21 cycles.
- cpu_req_i = 0 in IDLE: no state or array change. Changing the request while stalled is illegal.
- mem_ack_i outside WRITEBACK or ALLOCATE is ignored.
- Index wrap: addresses differing only in tag alias to the same line and evict each other.

Test Plan:
- Reset, then load 0x0000_0040 with memory line 0x40 word 0 = 0xDEAD_BEEF -> stall 11 cycles; one read transaction with mem_write_o = 0 and addr 0x40; then cpu_data_o = 0xDEAD_BEEF with stall low.
- Repeat the load of 0x40 -> hit, stall 0, data 0xDEAD_BEEF same cycle; no mem_enable_o activity.
- Store 0x1234_5678 to 0x44 (hit) -> no memory traffic. Load 0x44 -> 0x1234_5678; dirty[2] = 1.
- Load 0x0000_0440 (same index 2, new tag) -> writeback of line addr 0x40 with word 1 = 0x1234_5678 and mem_write_o = 1. Then a read of 0x440 with enable held across the transition. Stall 21 cycles; mem_enable_o low the cycle after the second ack.
- Store-miss to clean line 0x80 -> refill, then word written; dirty set; a later eviction writes back the merged line.
- Assert rst_i during ALLOCATE -> state IDLE and mem_enable_o = 0 immediately. A following load of the same address misses again (valid cleared).
